inst_encode_loader: RTL and testbench

- Inverse of the opcode decoder. Accepts field-level instruction records (opcode, registers, immediate, target) over a valid/ready stream.
- Packs each record into a 32-bit MIPS-format word using the team's 6-bit opcode map, then writes it into instruction memory through a write/ack handshake.
- Used at boot and by test harnesses to load programs that the control unit then decodes.

---
 rtl/mips_isa_pkg.sv | 54 +++++
 rtl/inst_field_packer.sv | 49 ++++
 rtl/inst_encode_loader.sv | 170 +++++++++++++++++
 tb/tb_inst_encode_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_isa_pkg
// Brief  : Opcode map, field bit positions and format/state enums shared by
//          the instruction encoder/loader.
// Rev    : 1.0  initial release
// ============================================================================
package mips_isa_pkg;

  localparam logic [5:0] c_RTYPE = 6'd0;
  localparam logic [5:0] c_BEQ   = 6'd1;
  localparam logic [5:0] c_BNE   = 6'd2;
  localparam logic [5:0] c_SW    = 6'd3;
  localparam logic [5:0] c_LW    = 6'd4;
  localparam logic [5:0] c_ADDI  = 6'd5;
  localparam logic [5:0] c_ANDI  = 6'd6;
  localparam logic [5:0] c_ORI   = 6'd7;
  localparam logic [5:0] c_SLTI  = 6'd8;
  localparam logic [5:0] c_JTYPE = 6'd9;

  localparam int c_OP_LSB     = 26;
  localparam int c_RS_LSB     = 21;
  localparam int c_RT_LSB     = 16;
  localparam int c_RD_LSB     = 11;
  localparam int c_SHAMT_LSB  = 6;
  localparam int c_FUNCT_LSB  = 0;
  localparam int c_IMM_LSB    = 0;
  localparam int c_TARGET_LSB = 0;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_BAD = 2'd3
  } inst_fmt_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_PAD    = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } loader_state_e;

  function automatic inst_fmt_e opFormat(input logic [5:0] op);
    if (op == c_RTYPE)     return FMT_R;
    else if (op == c_JTYPE) return FMT_J;
    else if (op <= c_SLTI)  return FMT_I;
    else                    return FMT_BAD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_field_packer.sv
`default_nettype none
// ============================================================================
// Module : inst_field_packer
// Brief  : Combinational packing of instruction fields into a 32-bit word.
// Rev    : 1.0  initial release
// ============================================================================
module inst_field_packer
  import mips_isa_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [5:0]  i_funct,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    case (opFormat(i_op))
      FMT_R: begin
        o_word[c_OP_LSB +: 6]    = i_op;
        o_word[c_RS_LSB +: 5]    = i_rs;
        o_word[c_RT_LSB +: 5]    = i_rt;
        o_word[c_RD_LSB +: 5]    = i_rd;
        o_word[c_SHAMT_LSB +: 5] = i_shamt;
        o_word[c_FUNCT_LSB +: 6] = i_funct;
      end
      FMT_I: begin
        o_word[c_OP_LSB +: 6]  = i_op;
        o_word[c_RS_LSB +: 5]  = i_rs;
        o_word[c_RT_LSB +: 5]  = i_rt;
        o_word[c_IMM_LSB +: 16] = i_imm;
      end
      FMT_J: begin
        o_word[c_OP_LSB +: 6]      = i_op;
        o_word[c_TARGET_LSB +: 26] = i_target;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inst_encode_loader.sv
`default_nettype none
// ============================================================================
// Module : inst_encode_loader
// Brief  : Encodes instruction records and writes them to instruction memory.
//          Optional trailing NOP padding when INST_NOP_PAD_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module inst_encode_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int BASE_ADDR     = 0,
  parameter int NOP_PAD_COUNT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

`ifdef INST_NOP_PAD_EN
  localparam bit c_PAD_EN = 1'b1;
`else
  localparam bit c_PAD_EN = 1'b0;
`endif
  localparam int              c_PAD_WORDS = c_PAD_EN ? NOP_PAD_COUNT : 0;
  localparam logic [ADDR_W-1:0] c_BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;

  loader_state_e     r_state, w_stNext;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_last;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_atMax;
`ifdef INST_NOP_PAD_EN
  logic [15:0]       r_padLeft;
`endif

  inst_field_packer u_packer (
    .i_op      (in_op),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_shamt   (in_shamt),
    .i_funct   (in_funct),
    .i_imm     (in_imm),
    .i_target  (in_target),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  assign w_atMax = (r_addr == c_ADDR_MAX);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_stNext;
  end

  always_comb begin
    w_stNext = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_stNext = ST_ACCEPT;
      ST_ACCEPT: if (in_valid) w_stNext = w_illegal ? ST_ERROR : ST_WRITE;
      ST_WRITE: begin
        if (imem_ack) begin
          // The last record may sit at the top address; only padding past it overflows.
          if (r_last) begin
            if (c_PAD_WORDS == 0) w_stNext = ST_DONE;
            else if (w_atMax)     w_stNext = ST_ERROR;
            else                  w_stNext = ST_PAD;
          end else if (w_atMax) begin
            w_stNext = ST_ERROR;
          end else begin
            w_stNext = ST_ACCEPT;
          end
        end
      end
`ifdef INST_NOP_PAD_EN
      ST_PAD: begin
        if (imem_ack) begin
          if (r_padLeft == 16'd1) w_stNext = ST_DONE;
          else if (w_atMax)       w_stNext = ST_ERROR;
        end
      end
`endif
      ST_DONE:  w_stNext = ST_IDLE;
      ST_ERROR: if (start) w_stNext = ST_ACCEPT;
      default:  w_stNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= c_BASE;
      r_wdata <= '0;
      r_last  <= 1'b0;
      r_count <= '0;
`ifdef INST_NOP_PAD_EN
      r_padLeft <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            r_addr  <= c_BASE;
            r_count <= '0;
          end
        end
        ST_ACCEPT: begin
          if (in_valid && !w_illegal) begin
            r_wdata <= w_word;
            r_last  <= in_last;
          end
        end
        ST_WRITE: begin
          if (imem_ack) begin
            r_count <= r_count + 1'b1;
            if ((!r_last || c_PAD_WORDS != 0) && !w_atMax) r_addr <= r_addr + 1'b1;
            if (r_last) r_wdata <= '0;
`ifdef INST_NOP_PAD_EN
            r_padLeft <= 16'(c_PAD_WORDS);
`endif
          end
        end
`ifdef INST_NOP_PAD_EN
        ST_PAD: begin
          if (imem_ack) begin
            r_count   <= r_count + 1'b1;
            r_padLeft <= r_padLeft - 1'b1;
            if (r_padLeft != 16'd1 && !w_atMax) r_addr <= r_addr + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_ACCEPT);
  assign imem_we    = (r_state == ST_WRITE) || (r_state == ST_PAD);
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_ERROR);
  assign done       = (r_state == ST_DONE);
  assign err        = (r_state == ST_ERROR);
  assign word_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_encode_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_encode_loader
// Brief  : Directed table-driven bench for inst_encode_loader (both builds).
// Rev    : 1.0  initial release
// ============================================================================
module tb_inst_encode_loader;

  localparam int PAD_N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        inValid = 1'b0;
  logic [5:0]  inOp = '0;
  logic [4:0]  inRs = '0, inRt = '0, inRd = '0, inShamt = '0;
  logic [5:0]  inFunct = '0;
  logic [15:0] inImm = '0;
  logic [25:0] inTarget = '0;
  logic        inLast = 1'b0;
  logic        imemAck = 1'b0;
  logic        sel = 1'b0;

  logic       aReady, aWe, aBusy, aDone, aErr;
  logic [7:0] aAddr;
  logic [31:0] aWdata;
  logic [8:0] aCount;
  logic       bReady, bWe, bBusy, bDone, bErr;
  logic [1:0] bAddr;
  logic [31:0] bWdata;
  logic [2:0] bCount;

  logic        mReady, mWe, mBusy, mDone, mErr;
  logic [7:0]  mAddr;
  logic [31:0] mWdata;
  logic [8:0]  mCount;

  assign mReady = sel ? bReady : aReady;
  assign mWe    = sel ? bWe    : aWe;
  assign mBusy  = sel ? bBusy  : aBusy;
  assign mDone  = sel ? bDone  : aDone;
  assign mErr   = sel ? bErr   : aErr;
  assign mAddr  = sel ? {6'd0, bAddr} : aAddr;
  assign mWdata = sel ? bWdata : aWdata;
  assign mCount = sel ? {6'd0, bCount} : aCount;

  always #5 clk = ~clk;

  inst_encode_loader #(.ADDR_W(8), .BASE_ADDR(0), .NOP_PAD_COUNT(PAD_N)) dutA (
    .clk(clk), .rst(rst), .start(start), .in_valid(inValid), .in_ready(aReady),
    .in_op(inOp), .in_rs(inRs), .in_rt(inRt), .in_rd(inRd), .in_shamt(inShamt),
    .in_funct(inFunct), .in_imm(inImm), .in_target(inTarget), .in_last(inLast),
    .imem_we(aWe), .imem_addr(aAddr), .imem_wdata(aWdata), .imem_ack(imemAck),
    .busy(aBusy), .done(aDone), .err(aErr), .word_count(aCount)
  );

  inst_encode_loader #(.ADDR_W(2), .BASE_ADDR(0), .NOP_PAD_COUNT(PAD_N)) dutB (
    .clk(clk), .rst(rst), .start(start), .in_valid(inValid), .in_ready(bReady),
    .in_op(inOp), .in_rs(inRs), .in_rt(inRt), .in_rd(inRd), .in_shamt(inShamt),
    .in_funct(inFunct), .in_imm(inImm), .in_target(inTarget), .in_last(inLast),
    .imem_we(bWe), .imem_addr(bAddr), .imem_wdata(bWdata), .imem_ack(imemAck),
    .busy(bBusy), .done(bDone), .err(bErr), .word_count(bCount)
  );

  typedef struct {
    string       nm;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] word;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic doStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pushRecord(input vec_t v, input logic last);
    int n = 0;
    while (!mReady && n < 20) begin @(negedge clk); n++; end
    check({v.nm, " in_ready"}, 32'(mReady), 32'd1);
    inOp = v.op; inRs = v.rs; inRt = v.rt; inRd = v.rd; inShamt = v.shamt;
    inFunct = v.funct; inImm = v.imm; inTarget = v.target; inLast = last;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic completeWrite(input string nm, input int delay,
                               input logic [7:0] eAddr, input logic [31:0] eWord);
    int n = 0;
    while (!mWe && n < 20) begin @(negedge clk); n++; end
    check({nm, " we"}, 32'(mWe), 32'd1);
    check({nm, " addr"}, 32'(mAddr), 32'(eAddr));
    check({nm, " wdata"}, mWdata, eWord);
    for (int i = 0; i < delay; i++) begin
      imemAck = 1'b0;
      @(negedge clk);
      check({nm, " we held"}, 32'(mWe), 32'd1);
      check({nm, " addr held"}, 32'(mAddr), 32'(eAddr));
      check({nm, " wdata held"}, mWdata, eWord);
      check({nm, " ready low"}, 32'(mReady), 32'd0);
    end
    imemAck = 1'b1;
    @(negedge clk);
    imemAck = 1'b0;
  endtask

  task automatic finishSession(input string nm, input int nRec, input logic [7:0] lastAddr);
    int total = nRec;
`ifdef INST_NOP_PAD_EN
    for (int k = 0; k < PAD_N; k++)
      completeWrite({nm, " pad"}, 0, lastAddr + 8'(k + 1), 32'h0);
    total = nRec + PAD_N;
`endif
    check({nm, " done"}, 32'(mDone), 32'd1);
    check({nm, " count"}, 32'(mCount), 32'(total));
    @(negedge clk);
    check({nm, " done drop"}, 32'(mDone), 32'd0);
    check({nm, " idle"}, 32'(mBusy), 32'd0);
  endtask

  vec_t tbl[9];
  vec_t vR, vJ, vBad, vAddi;

  initial begin
    tbl[0] = '{"addi",  6'd5, 5'd1,  5'd2,  5'd0,  5'd0, 6'd0,  16'h0005, 26'h0,       32'h14220005};
    tbl[1] = '{"beq",   6'd1, 5'd2,  5'd3,  5'd0,  5'd0, 6'd0,  16'hFFFC, 26'h0,       32'h0443FFFC};
    tbl[2] = '{"sw",    6'd3, 5'd29, 5'd8,  5'd0,  5'd0, 6'd0,  16'h0010, 26'h0,       32'h0FA80010};
    tbl[3] = '{"ori",   6'd7, 5'd0,  5'd9,  5'd0,  5'd0, 6'd0,  16'hABCD, 26'h0,       32'h1C09ABCD};
    tbl[4] = '{"slti",  6'd8, 5'd31, 5'd31, 5'd0,  5'd0, 6'd0,  16'h8000, 26'h0,       32'h23FF8000};
    tbl[5] = '{"sll",   6'd0, 5'd0,  5'd7,  5'd9,  5'd4, 6'd0,  16'hFFFF, 26'h0,       32'h00074900};
    tbl[6] = '{"jmax",  6'd9, 5'd0,  5'd0,  5'd0,  5'd0, 6'd0,  16'h0,    26'h3FFFFFF, 32'h27FFFFFF};
    tbl[7] = '{"andi",  6'd6, 5'd5,  5'd6,  5'd31, 5'd31, 6'h3F, 16'h00FF, 26'h3FFFFFF, 32'h18A600FF};
    tbl[8] = '{"lw",    6'd4, 5'd1,  5'd2,  5'd0,  5'd0, 6'd0,  16'h0004, 26'h0,       32'h10220004};
    vR    = '{"rtype",  6'd0, 5'd3,  5'd4,  5'd5,  5'd0, 6'h20, 16'h0,    26'h0,       32'h00642820};
    vJ    = '{"j",      6'd9, 5'd0,  5'd0,  5'd0,  5'd0, 6'd0,  16'h0,    26'h0000010, 32'h24000010};
    vBad  = '{"bad",    6'd12, 5'd1, 5'd1,  5'd1,  5'd1, 6'd1,  16'h1,    26'h1,       32'h0};
    vAddi = tbl[0];

    repeat (3) @(negedge clk);
    check("rst in_ready", 32'(mReady), 32'd0);
    check("rst we", 32'(mWe), 32'd0);
    check("rst addr", 32'(mAddr), 32'd0);
    check("rst wdata", mWdata, 32'd0);
    check("rst busy", 32'(mBusy), 32'd0);
    check("rst done", 32'(mDone), 32'd0);
    check("rst err", 32'(mErr), 32'd0);
    check("rst count", 32'(mCount), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single-record sessions, one per encoding pattern.
    for (int i = 0; i < 9; i++) begin
      doStart();
      check({tbl[i].nm, " busy"}, 32'(mBusy), 32'd1);
      pushRecord(tbl[i], 1'b1);
      completeWrite(tbl[i].nm, 0, 8'd0, tbl[i].word);
      finishSession(tbl[i].nm, 1, 8'd0);
    end

    // Two records with delayed acks; start mid-session must be ignored.
    doStart();
    pushRecord(vR, 1'b0);
    completeWrite("rtype", 3, 8'd0, vR.word);
    check("mid count", 32'(mCount), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start ignored addr", 32'(mAddr), 32'd1);
    check("start ignored count", 32'(mCount), 32'd1);
    pushRecord(vJ, 1'b1);
    completeWrite("j", 3, 8'd1, vJ.word);
    finishSession("two rec", 2, 8'd1);

    // Illegal opcode, then recovery via start.
    doStart();
    pushRecord(vBad, 1'b0);
    check("bad err", 32'(mErr), 32'd1);
    check("bad we", 32'(mWe), 32'd0);
    check("bad busy", 32'(mBusy), 32'd0);
    check("bad ready", 32'(mReady), 32'd0);
    imemAck = 1'b1;
    @(negedge clk);
    imemAck = 1'b0;
    check("bad err sticky", 32'(mErr), 32'd1);
    check("bad no we", 32'(mWe), 32'd0);
    doStart();
    check("recover err", 32'(mErr), 32'd0);
    check("recover busy", 32'(mBusy), 32'd1);
    check("recover addr", 32'(mAddr), 32'd0);
    check("recover count", 32'(mCount), 32'd0);
    pushRecord(vAddi, 1'b1);
    completeWrite("recover", 1, 8'd0, vAddi.word);
    finishSession("recover", 1, 8'd0);

    // Reset while a write is pending; the word is dropped.
    doStart();
    pushRecord(vAddi, 1'b0);
    check("pre rst we", 32'(mWe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort we", 32'(mWe), 32'd0);
    check("abort busy", 32'(mBusy), 32'd0);
    check("abort ready", 32'(mReady), 32'd0);
    check("abort count", 32'(mCount), 32'd0);
    imemAck = 1'b1;
    repeat (2) @(negedge clk);
    imemAck = 1'b0;
    check("stray ack count", 32'(mCount), 32'd0);
    check("stray ack we", 32'(mWe), 32'd0);

    // Narrow address space: overflow, then a session ending at the top address.
    sel = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    doStart();
    for (int i = 0; i < 4; i++) begin
      pushRecord(tbl[i], 1'b0);
      completeWrite("ovf", 0, 8'(i), tbl[i].word);
    end
    check("ovf err", 32'(mErr), 32'd1);
    check("ovf count", 32'(mCount), 32'd4);
    check("ovf we", 32'(mWe), 32'd0);
    check("ovf ready", 32'(mReady), 32'd0);
    doStart();
    for (int i = 0; i < 4; i++) begin
      pushRecord(tbl[i], (i == 3));
      completeWrite("full", 0, 8'(i), tbl[i].word);
    end
`ifdef INST_NOP_PAD_EN
    check("full pad ovf err", 32'(mErr), 32'd1);
    check("full pad ovf count", 32'(mCount), 32'd4);
`else
    check("full done", 32'(mDone), 32'd1);
    check("full err", 32'(mErr), 32'd0);
    check("full count", 32'(mCount), 32'd4);
`endif
    sel = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
